temp_sensor_reader: RTL and testbench

- Responder side of the C1 enable/ready handshake. While en_i is high, it repeatedly reads a serial temperature sensor over a 3-wire SPI-style link (cs_n, sclk, miso; mode 0).
- For each good frame it presents a 9-bit temperature and pulses listo_o for exactly one cycle.
- It sits between the top-level sequencing FSM (which drives en_i and consumes listo_o and temperatura_o) and the board sensor pins.

---
 rtl/temp_sensor_reader_pkg.sv | 29 ++
 rtl/temp_sensor_reader_if.sv | 14 +
 rtl/temp_sensor_reader_spi_rx_shifter.sv | 77 +++++++
 rtl/temp_sensor_reader.sv | 121 ++++++++++++
 tb/tb_temp_sensor_reader.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/temp_sensor_reader_pkg.sv
// Shared definitions for the temperature sensor reader: FSM states, frame field
// positions and a counter sizing helper.
package temp_sensor_pkg;

   localparam int FRAME_BITS = 16;
   localparam int TEMP_MSB   = 14;
   localparam int TEMP_LSB   = 6;
   localparam int OPEN_BIT   = 2;
   localparam int TEMP_W     = TEMP_MSB - TEMP_LSB + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DONE  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [TEMP_W-1:0] frame_temp(input logic [FRAME_BITS-1:0] f);
      return f[TEMP_MSB:TEMP_LSB];
   endfunction

endpackage

// File: rtl/temp_sensor_reader_if.sv
// Enable/ready link between the sequencing FSM (master) and the sensor reader (slave).
interface temp_sensor_reader_if;
   import temp_sensor_pkg::*;

   logic              en_i;
   logic              listo_o;
   logic [TEMP_W-1:0] temperatura_o;
   logic              err_o;
   logic              busy_o;

   modport master (output en_i, input listo_o, temperatura_o, err_o, busy_o);
   modport slave  (input en_i, output listo_o, temperatura_o, err_o, busy_o);

endinterface

// File: rtl/temp_sensor_reader_spi_rx_shifter.sv
// Mode-0 receive engine: while i_run is high, emits sclk (CLK_DIV low + CLK_DIV high
// per bit), shifts synchronised miso on each rising sclk, and pulses bit/frame done.
module spi_rx_shifter
   import temp_sensor_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_run,
   input  logic                  i_miso,
   output logic                  o_sclk,
   output logic                  o_bit_done,
   output logic                  o_frame_done,
   output logic [FRAME_BITS-1:0] o_frame
);

   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   logic                  r_sync1;
   logic                  r_sync2;
   logic [DIV_W-1:0]      r_div;
   logic [BIT_W-1:0]      r_bit;
   logic                  r_sclk;
   logic                  r_bit_done;
   logic                  r_frame_done;
   logic [FRAME_BITS-1:0] r_shift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_div        <= '0;
         r_bit        <= '0;
         r_sclk       <= 1'b0;
         r_bit_done   <= 1'b0;
         r_frame_done <= 1'b0;
         r_shift      <= '0;
      end else begin
         r_sync1      <= i_miso;
         r_sync2      <= r_sync1;
         r_bit_done   <= 1'b0;
         r_frame_done <= 1'b0;
         if (!i_run) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
         end else if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk) begin
               r_sclk  <= 1'b1;
               r_shift <= {r_shift[FRAME_BITS-2:0], r_sync2};
            end else begin
               r_sclk     <= 1'b0;
               r_bit_done <= 1'b1;
               if (r_bit == BIT_LAST) begin
                  r_frame_done <= 1'b1;
                  r_bit        <= '0;
               end else begin
                  r_bit <= r_bit + 1'b1;
               end
            end
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   assign o_sclk       = r_sclk;
   assign o_bit_done   = r_bit_done;
   assign o_frame_done = r_frame_done;
   assign o_frame      = r_shift;

endmodule

// File: rtl/temp_sensor_reader.sv
// Reads a 16-bit serial temperature frame while enabled; listo_o pulses one cycle
// CS_SETUP + 32*CLK_DIV + 1 edges after enable, then waits CONV_WAIT before the next frame.
module temp_sensor_reader
   import temp_sensor_pkg::*;
#(
   parameter int CLK_DIV   = 25,
   parameter int CS_SETUP  = 4,
   parameter int CONV_WAIT = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   temp_sensor_reader_if.slave  ctl,
   input  logic                 miso_i,
   output logic                 cs_n_o,
   output logic                 sclk_o
);

   localparam int CNT_W = $clog2(max3(CS_SETUP, CONV_WAIT, FRAME_BITS)) + 1;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_cs_n;
   logic                  r_listo;
   logic                  r_err;
   logic [TEMP_W-1:0]     r_temp;

   logic                  w_run;
   logic                  w_bit_done;
   logic                  w_frame_done;
   logic [FRAME_BITS-1:0] w_frame;

   // Stop the shifter on the same edge as an abort or frame end so sclk never rises then.
   assign w_run = (r_state == ST_SHIFT) && ctl.en_i && !w_frame_done;

   spi_rx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk          (clk),
      .rst          (rst),
      .i_run        (w_run),
      .i_miso       (miso_i),
      .o_sclk       (sclk_o),
      .o_bit_done   (w_bit_done),
      .o_frame_done (w_frame_done),
      .o_frame      (w_frame)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cs_n  <= 1'b1;
         r_listo <= 1'b0;
         r_err   <= 1'b0;
         r_temp  <= '0;
      end else begin
         r_listo <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ctl.en_i) begin
                  r_state <= ST_SETUP;
                  r_cs_n  <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            ST_SETUP: begin
               if (!ctl.en_i) begin
                  r_state <= ST_IDLE;
                  r_cs_n  <= 1'b1;
               end else if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!ctl.en_i) begin
                  r_state <= ST_IDLE;
                  r_cs_n  <= 1'b1;
               end else if (w_frame_done && (r_cnt == CNT_W'(FRAME_BITS - 1))) begin
                  r_state <= ST_DONE;
                  r_cs_n  <= 1'b1;
                  r_listo <= 1'b1;
                  r_err   <= w_frame[OPEN_BIT];
                  if (!w_frame[OPEN_BIT]) begin
                     r_temp <= frame_temp(w_frame);
                  end
               end else if (w_bit_done) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_WAIT;
               r_cnt   <= '0;
            end
            ST_WAIT: begin
               // DONE already holds cs_n high for one of the CONV_WAIT idle cycles.
               if (!ctl.en_i) begin
                  r_state <= ST_IDLE;
               end else if ((int'(r_cnt) + 2) >= CONV_WAIT) begin
                  r_state <= ST_SETUP;
                  r_cs_n  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cs_n  <= 1'b1;
            end
         endcase
      end
   end

   assign cs_n_o            = r_cs_n;
   assign ctl.listo_o       = r_listo;
   assign ctl.err_o         = r_err;
   assign ctl.temperatura_o = r_temp;
   assign ctl.busy_o        = ~r_cs_n;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Directed bench for temp_sensor_reader with a mode-0 sensor model (CLK_DIV=2,
// CS_SETUP=2, CONV_WAIT=10).
module tb_temp_sensor_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic miso;
   logic cs_n;
   logic sclk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] sensor_frame = 16'h3480;
   logic [3:0]  sidx         = 4'd15;
   int          sclk_rises   = 0;

   temp_sensor_reader_if u_if ();

   temp_sensor_reader #(
      .CLK_DIV   (2),
      .CS_SETUP  (2),
      .CONV_WAIT (10)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ctl    (u_if),
      .miso_i (miso),
      .cs_n_o (cs_n),
      .sclk_o (sclk)
   );

   always #5 clk = ~clk;

   // Sensor presents the MSB at chip-select and moves to the next bit right after each
   // rising sclk, so every bit is stable for the whole following low phase.
   always @(negedge cs_n or posedge sclk) begin
      if (sclk) begin
         sclk_rises = sclk_rises + 1;
         if (sidx != 4'd0) sidx = sidx - 4'd1;
      end else begin
         sidx       = 4'd15;
         sclk_rises = 0;
      end
   end
   assign miso = sensor_frame[sidx];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_listo(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!u_if.listo_o && n < limit);
   endtask

   initial begin
      int n;
      int hi;
      int pulses;
      int lows;

      u_if.en_i = 1'b0;
      tick();
      tick();
      chk("rst_cs_n",  32'(cs_n), 32'd1);
      chk("rst_sclk",  32'(sclk), 32'd0);
      chk("rst_temp",  32'(u_if.temperatura_o), 32'h0);
      chk("rst_listo", 32'(u_if.listo_o), 32'd0);
      chk("rst_err",   32'(u_if.err_o), 32'd0);
      chk("rst_busy",  32'(u_if.busy_o), 32'd0);
      rst = 1'b0;
      tick();

      // Frame 1: good reading 0x0D2
      sensor_frame = 16'h3480;
      u_if.en_i = 1'b1;
      tick();
      chk("setup_cs_low", 32'(cs_n), 32'd0);
      chk("setup_busy",   32'(u_if.busy_o), 32'd1);
      wait_listo(2000, n);
      chk("f1_latency", 32'(n), 32'd67);
      chk("f1_temp",    32'(u_if.temperatura_o), 32'h0D2);
      chk("f1_err",     32'(u_if.err_o), 32'd0);
      chk("f1_rises",   32'(sclk_rises), 32'd16);
      chk("f1_done_cs", 32'(cs_n), 32'd1);
      chk("f1_done_sclk", 32'(sclk), 32'd0);

      // Frame 2: open flag set, temperature must hold
      sensor_frame = 16'h7FC4;
      hi = 0;
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (cs_n) hi++;
         if (u_if.listo_o) pulses++;
      end
      chk("f2_wait_cs_high", 32'(hi), 32'd9);
      chk("f2_no_double",    32'(pulses), 32'd0);
      wait_listo(2000, n);
      chk("f2_spacing", 32'(n + 9), 32'd77);
      chk("f2_err",     32'(u_if.err_o), 32'd1);
      chk("f2_temp",    32'(u_if.temperatura_o), 32'h0D2);
      chk("f2_rises",   32'(sclk_rises), 32'd16);

      // Frame 3: good again
      sensor_frame = 16'h3480;
      tick();
      chk("f3_listo_drop", 32'(u_if.listo_o), 32'd0);
      wait_listo(2000, n);
      chk("f3_spacing", 32'(n + 1), 32'd77);
      chk("f3_err",     32'(u_if.err_o), 32'd0);
      chk("f3_temp",    32'(u_if.temperatura_o), 32'h0D2);

      // Abort after 5 rising sclk edges
      sensor_frame = 16'h1230;
      for (int i = 0; i < 300 && cs_n; i++) tick();
      chk("ab_cs_fall", 32'(cs_n), 32'd0);
      for (int i = 0; i < 300 && sclk_rises < 5; i++) tick();
      chk("ab_rises5", 32'(sclk_rises), 32'd5);
      u_if.en_i = 1'b0;
      tick();
      chk("ab_cs_n",  32'(cs_n), 32'd1);
      chk("ab_sclk",  32'(sclk), 32'd0);
      chk("ab_busy",  32'(u_if.busy_o), 32'd0);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (u_if.listo_o) pulses++;
      end
      chk("ab_no_listo", 32'(pulses), 32'd0);
      chk("ab_temp",     32'(u_if.temperatura_o), 32'h0D2);
      chk("ab_err",      32'(u_if.err_o), 32'd0);

      // Re-enable: a fresh full frame reading 0x048
      u_if.en_i = 1'b1;
      tick();
      wait_listo(2000, n);
      chk("re_latency", 32'(n), 32'd67);
      chk("re_rises",   32'(sclk_rises), 32'd16);
      chk("re_temp",    32'(u_if.temperatura_o), 32'h048);
      chk("re_err",     32'(u_if.err_o), 32'd0);

      // Enable dropped during DONE: pulse completes, then FSM idles
      sensor_frame = 16'h3480;
      tick();
      wait_listo(2000, n);
      chk("dd_spacing", 32'(n + 1), 32'd77);
      u_if.en_i = 1'b0;
      chk("dd_temp", 32'(u_if.temperatura_o), 32'h0D2);
      tick();
      chk("dd_listo_one", 32'(u_if.listo_o), 32'd0);
      pulses = 0;
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (u_if.listo_o) pulses++;
         if (!cs_n) lows++;
      end
      chk("dd_no_listo", 32'(pulses), 32'd0);
      chk("dd_idle_cs",  32'(lows), 32'd0);

      // Asynchronous reset in the middle of SHIFT
      u_if.en_i = 1'b1;
      for (int i = 0; i < 300 && cs_n; i++) tick();
      for (int i = 0; i < 300 && sclk_rises < 3; i++) tick();
      chk("rs_rises3", 32'(sclk_rises), 32'd3);
      #3;
      rst = 1'b1;
      #1;
      chk("rs_cs_n",  32'(cs_n), 32'd1);
      chk("rs_sclk",  32'(sclk), 32'd0);
      chk("rs_temp",  32'(u_if.temperatura_o), 32'h0);
      chk("rs_listo", 32'(u_if.listo_o), 32'd0);
      chk("rs_err",   32'(u_if.err_o), 32'd0);
      chk("rs_busy",  32'(u_if.busy_o), 32'd0);
      u_if.en_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
